// File: rtl/spi_reg_bank_if.sv
// SPI bus bundle between the Raspberry Pi master (cs0) and spi_reg_bank.
//   spi_cs_n    : chip select, active low, asynchronous to sys_clk
//   spi_clk     : SPI clock, mode 0, asynchronous to sys_clk
//   spi_mosi    : master-to-slave data, MSB first
//   spi_miso    : slave-to-master data
//   spi_miso_oe : MISO drive enable, high while the slave is selected
// slave modport is used by the register bank, master modport by whoever
// drives the bus.
interface spi_reg_bank_if;
  logic spi_cs_n;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport slave  (input  spi_cs_n, spi_clk, spi_mosi, output spi_miso, spi_miso_oe);
  modport master (output spi_cs_n, spi_clk, spi_mosi, input  spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-slave register bank running entirely in the clk domain.
// Frame = command byte {rw, addr[6:0]} followed by DATA_WIDTH-bit words with
// address auto-increment (127 wraps to 0).
//   clk, reset_n   : system clock, asynchronous active-low reset
//   spi            : SPI bus (slave modport), oversampled by clk (sclk <= clk/8)
//   in_regs        : read-only status words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_regs       : R/W control registers, packed like in_regs
//   reg_wr_strobe  : one-clk pulse per control register on write
//   coef_wr/addr/data : coefficient window write port (addr = address - COEF_BASE)
//   frame_err      : one-clk pulse when a frame ends with a partial word
module spi_reg_bank #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_OUT_REGS = 8,
  parameter int NUM_IN_REGS  = 4,
  parameter int COEF_BASE    = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  spi_reg_bank_if.slave                       spi,
  input  logic [NUM_IN_REGS*DATA_WIDTH-1:0]   in_regs,
  output logic [NUM_OUT_REGS*DATA_WIDTH-1:0]  out_regs,
  output logic [NUM_OUT_REGS-1:0]             reg_wr_strobe,
  output logic                                coef_wr,
  output logic [6:0]                          coef_addr,
  output logic [DATA_WIDTH-1:0]               coef_data,
  output logic                                frame_err
);

  localparam int            CW            = 6;
  localparam logic [CW-1:0] LAST_CMD_BIT  = 6'd7;
  localparam logic [CW-1:0] LAST_DATA_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [7:0]    STAT_END      = 8'(NUM_OUT_REGS + NUM_IN_REGS);
  localparam logic [6:0]    COEF_LO       = 7'(COEF_BASE);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2} state_t;

  state_t                            state_q;
  logic [2:0]                        cs_sync_q;
  logic [2:0]                        sclk_sync_q;
  logic [1:0]                        mosi_sync_q;
  logic                              rw_q;
  logic [6:0]                        addr_q;
  logic [CW-1:0]                     bit_cnt_q;
  logic [DATA_WIDTH-2:0]             sh_in_q;
  logic [DATA_WIDTH-1:0]             sh_out_q;
  logic                              miso_q;
  logic                              miso_oe_q;
  logic [NUM_OUT_REGS*DATA_WIDTH-1:0] out_regs_q;
  logic [NUM_OUT_REGS-1:0]           strobe_q;
  logic                              coef_wr_q;
  logic [6:0]                        coef_addr_q;
  logic [DATA_WIDTH-1:0]             coef_data_q;
  logic                              frame_err_q;

  logic                  cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic [DATA_WIDTH-1:0] word_in_s;
  logic                  last_bit_s;
  logic                  partial_s;
  logic [6:0]            rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_val_d;

  // Synchronisers: the cs chain resets low so a cs that is already low at
  // reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= 3'b000;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], spi.spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[1:0], spi.spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
    end
  end

  // Edge detection, incoming word assembly and the read-data lookup.
  always_comb begin
    cs_fall_s   =  cs_sync_q[2] & ~cs_sync_q[1];
    cs_rise_s   = ~cs_sync_q[2] &  cs_sync_q[1];
    sclk_rise_s = ~sclk_sync_q[2] &  sclk_sync_q[1];
    sclk_fall_s =  sclk_sync_q[2] & ~sclk_sync_q[1];
    word_in_s   = {sh_in_q, mosi_sync_q[1]};
    last_bit_s  = (state_q == ST_CMD) ? (bit_cnt_q == LAST_CMD_BIT)
                                      : (bit_cnt_q == LAST_DATA_BIT);
    // Bits held after this clk; a final edge coinciding with cs rise completes the word.
    partial_s   = sclk_rise_s ? ~last_bit_s : (bit_cnt_q != 6'd0);
    // In CMD the address is the one being latched now, in DATA the next one.
    rd_addr_s   = (state_q == ST_CMD) ? word_in_s[6:0] : (addr_q + 7'd1);
    rd_val_d    = '0;
    for (int k = 0; k < NUM_OUT_REGS; k++) begin
      rd_val_d = rd_val_d | ((rd_addr_s == 7'(k)) ? out_regs_q[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
    for (int k = 0; k < NUM_IN_REGS; k++) begin
      rd_val_d = rd_val_d | ((rd_addr_s == 7'(NUM_OUT_REGS + k)) ? in_regs[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  // Frame state machine with all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      bit_cnt_q   <= 6'd0;
      sh_in_q     <= '0;
      sh_out_q    <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      out_regs_q  <= '0;
      strobe_q    <= '0;
      coef_wr_q   <= 1'b0;
      coef_addr_q <= 7'd0;
      coef_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      strobe_q    <= '0;
      coef_wr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 6'd0;
            sh_out_q  <= '0;
            miso_oe_q <= 1'b1;
            miso_q    <= 1'b0;
          end
        end
        ST_CMD, ST_DATA: begin
          if (sclk_rise_s) begin
            sh_in_q <= word_in_s[DATA_WIDTH-2:0];
            if (last_bit_s) begin
              bit_cnt_q <= 6'd0;
              if (state_q == ST_CMD) begin
                rw_q     <= word_in_s[7];
                addr_q   <= word_in_s[6:0];
                state_q  <= ST_DATA;
                sh_out_q <= word_in_s[7] ? rd_val_d : '0;
              end else begin
                if (!rw_q) begin
                  for (int k = 0; k < NUM_OUT_REGS; k++) begin
                    if (addr_q == 7'(k)) begin
                      out_regs_q[k*DATA_WIDTH +: DATA_WIDTH] <= word_in_s;
                      strobe_q[k] <= 1'b1;
                    end
                  end
                  // Control/status addresses win over an overlapping window.
                  if ((addr_q >= COEF_LO) && ({1'b0, addr_q} >= STAT_END)) begin
                    coef_wr_q   <= 1'b1;
                    coef_addr_q <= addr_q - COEF_LO;
                    coef_data_q <= word_in_s;
                  end
                end
                addr_q   <= addr_q + 7'd1;
                sh_out_q <= rw_q ? rd_val_d : '0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end else if (sclk_fall_s) begin
            miso_q   <= sh_out_q[DATA_WIDTH-1];
            sh_out_q <= {sh_out_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (cs_rise_s) begin
            state_q     <= ST_IDLE;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= partial_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = miso_oe_q;
  assign out_regs        = out_regs_q;
  assign reg_wr_strobe   = strobe_q;
  assign coef_wr         = coef_wr_q;
  assign coef_addr       = coef_addr_q;
  assign coef_data       = coef_data_q;
  assign frame_err       = frame_err_q;

endmodule
